instruction_fetch_unit: RTL

- Upstream neighbour of the single-cycle RV64I control unit.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents the fetched instruction, its opcode field and its PC to decode/control with a valid/ready handshake.
- Advances the PC on pc_write_enable, either sequentially or via a redirect from branch/jump resolution or a flush. Misaligned targets and bus errors are trapped in a sticky fault state.

---
 rtl/instruction_fetch_unit_pkg.sv | 38 +++
 rtl/instruction_fetch_unit_fetch_pc_reg.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, fault causes,
// the reset/fault NOP word and the RV64I major opcodes decoded by control.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_MISALIGNED = 2'b01,
    CAUSE_BUS_ERROR  = 2'b10
  } fault_cause_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST_WORD = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;

  // Instruction fetch targets must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// Architectural PC register with sequential/redirect next-PC mux, +4 adder and
// word-alignment checks on both the redirect target and the current PC.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect_misaligned,
  output logic            pc_misaligned
);

  logic [XLEN-1:0] seq_pc;

  // Wraps modulo 2^XLEN by construction.
  assign seq_pc              = pc + XLEN'(4);
  assign next_pc             = redirect_valid ? redirect_pc : seq_pc;
  assign redirect_misaligned = is_misaligned(redirect_pc[1:0]);
  assign pc_misaligned       = is_misaligned(pc[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word fetches over req/ack, holds one instruction
// for decode under valid/ready, and traps misaligned targets or bus errors.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = NOP_INST_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write_enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_error,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [6:0]      inst_opcode,
  output logic [XLEN-1:0] inst_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fetch_count,
  output logic [1:0]      fsm_state
);

  // Handshakes: the memory side holds imem_req/imem_addr stable until a one-cycle
  // imem_ack (rdata/error valid only with ack); the decode side holds inst_valid and
  // all inst_* outputs stable until inst_ready && pc_write_enable retires the word.

  fetch_state_e    state, state_next;
  fault_cause_e    fault_cause_q, fault_cause_next;
  logic [XLEN-1:0] pc, next_pc, drain_addr, fault_pc_next;
  logic            redirect_misaligned, pc_misaligned;
  logic            pc_load, capture_inst, capture_drain, set_fault, count_inc;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc_reg (
    .clk                 (clk),
    .rst                 (rst),
    .load                (pc_load),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .pc                  (pc),
    .next_pc             (next_pc),
    .redirect_misaligned (redirect_misaligned),
    .pc_misaligned       (pc_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_load          = 1'b0;
    capture_inst     = 1'b0;
    capture_drain    = 1'b0;
    set_fault        = 1'b0;
    count_inc        = 1'b0;
    fault_cause_next = CAUSE_NONE;
    fault_pc_next    = '0;
    case (state)
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          if (!imem_ack) begin
            // A misaligned target is only trapped once the old request drains.
            capture_drain = 1'b1;
            state_next    = ST_DRAIN;
          end else if (redirect_misaligned) begin
            set_fault        = 1'b1;
            fault_cause_next = CAUSE_MISALIGNED;
            fault_pc_next    = redirect_pc;
            state_next       = ST_FAULT;
          end
        end else if (imem_ack) begin
          if (imem_error) begin
            set_fault        = 1'b1;
            fault_cause_next = CAUSE_BUS_ERROR;
            fault_pc_next    = pc;
            state_next       = ST_FAULT;
          end else begin
            capture_inst = 1'b1;
            state_next   = ST_VALID;
          end
        end
      end
      ST_DRAIN: begin
        pc_load = redirect_valid;
        if (imem_ack) begin
          if (redirect_valid ? redirect_misaligned : pc_misaligned) begin
            set_fault        = 1'b1;
            fault_cause_next = CAUSE_MISALIGNED;
            fault_pc_next    = redirect_valid ? redirect_pc : pc;
            state_next       = ST_FAULT;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
      ST_VALID: begin
        if (inst_ready && pc_write_enable) begin
          pc_load   = 1'b1;
          count_inc = 1'b1;
          if (redirect_valid && redirect_misaligned) begin
            set_fault        = 1'b1;
            fault_cause_next = CAUSE_MISALIGNED;
            fault_pc_next    = redirect_pc;
            state_next       = ST_FAULT;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_addr    <= RESET_PC;
      inst          <= NOP_INST;
      inst_pc       <= RESET_PC;
      fault_pc      <= '0;
      fault_cause_q <= CAUSE_NONE;
      fetch_count   <= '0;
    end else begin
      if (capture_drain) begin
        drain_addr <= pc;
      end
      if (capture_inst) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
      if (set_fault) begin
        inst          <= NOP_INST;
        fault_pc      <= fault_pc_next;
        fault_cause_q <= fault_cause_next;
      end
      if (count_inc) begin
        fetch_count <= fetch_count + XLEN'(1);
      end
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc;
    inst_valid = 1'b0;
    fault      = 1'b0;
    case (state)
      ST_FETCH: imem_req = !rst;
      ST_DRAIN: begin
        imem_req  = !rst;
        imem_addr = drain_addr;
      end
      ST_VALID: inst_valid = 1'b1;
      ST_FAULT: fault = 1'b1;
      default:  imem_req = 1'b0;
    endcase
  end

  assign inst_opcode = inst[6:0];
  assign fault_cause = fault_cause_q;
  assign fsm_state   = state;

endmodule
